// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter and sequencer sharing one combinational ALU between two requesters.
//
// Each requester presents a command (a, b, sel) with valid/ready. In IDLE one winner is
// chosen (sole requester, or the pointer's requester when both are valid). The accepted
// command drives the ALU for one EXEC cycle. The ALU's result and flags are captured into
// the owner's response registers, which pulse rsp*_valid for one cycle.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   reqN_valid/ready/a/b/sel     command handshake and payload for requester N
//   rspN_valid/result/carry/zero/illegal
//                                one-cycle response pulse and held result for requester N
//   alu_a, alu_b, alu_sel        registered operands and select driven to the shared ALU
//   alu_out, alu_carry, alu_zero result and flags returned by the shared ALU
//   busy                         high while a command is executing
module alu_rr_arbiter #(
  parameter int unsigned DW      = 4,
  parameter int unsigned SW      = 4,
  parameter int unsigned MAX_SEL = 8
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [SW-1:0] req0_sel,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [SW-1:0] req1_sel,

  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_result,
  output logic          rsp0_carry,
  output logic          rsp0_zero,
  output logic          rsp0_illegal,

  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_result,
  output logic          rsp1_carry,
  output logic          rsp1_zero,
  output logic          rsp1_illegal,

  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [SW-1:0] alu_sel,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  input  logic          alu_zero,

  output logic          busy
);

  localparam logic [SW-1:0] MaxSel = SW'(MAX_SEL);

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  state_e        state_q, state_d;
  // Pointer: 0 gives requester 0 priority on a tie, 1 gives requester 1 priority.
  logic          ptr_q, ptr_d;
  logic          owner_q, owner_d;

  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [SW-1:0] alu_sel_q, alu_sel_d;

  logic          rsp0_valid_q, rsp0_valid_d;
  logic [DW-1:0] rsp0_result_q, rsp0_result_d;
  logic          rsp0_carry_q, rsp0_carry_d;
  logic          rsp0_zero_q, rsp0_zero_d;
  logic          rsp0_illegal_q, rsp0_illegal_d;

  logic          rsp1_valid_q, rsp1_valid_d;
  logic [DW-1:0] rsp1_result_q, rsp1_result_d;
  logic          rsp1_carry_q, rsp1_carry_d;
  logic          rsp1_zero_q, rsp1_zero_d;
  logic          rsp1_illegal_q, rsp1_illegal_d;

  logic          grant0, grant1;
  logic          sel_illegal;

  // Winner selection: a lone requester wins; on a tie the pointer decides.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
      grant0 = req0_valid & (~req1_valid | ~ptr_q);
      grant1 = req1_valid & (~req0_valid |  ptr_q);
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  // The ALU select register holds the in-flight command's select during EXEC.
  assign sel_illegal = (alu_sel_q > MaxSel);

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_sel_d      = alu_sel_q;

    rsp0_valid_d   = 1'b0;
    rsp0_result_d  = rsp0_result_q;
    rsp0_carry_d   = rsp0_carry_q;
    rsp0_zero_d    = rsp0_zero_q;
    rsp0_illegal_d = rsp0_illegal_q;

    rsp1_valid_d   = 1'b0;
    rsp1_result_d  = rsp1_result_q;
    rsp1_carry_d   = rsp1_carry_q;
    rsp1_zero_d    = rsp1_zero_q;
    rsp1_illegal_d = rsp1_illegal_q;

    unique case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          // Latch the command straight into the ALU-facing registers.
          alu_a_d   = grant1 ? req1_a   : req0_a;
          alu_b_d   = grant1 ? req1_b   : req0_b;
          alu_sel_d = grant1 ? req1_sel : req0_sel;
          owner_d   = grant1;
          // Hand priority to the requester that just lost (or was absent).
          ptr_d     = grant0;
          state_d   = StExec;
        end
      end
      StExec: begin
        if (!owner_q) begin
          rsp0_valid_d   = 1'b1;
          rsp0_result_d  = alu_out;
          rsp0_carry_d   = alu_carry;
          rsp0_zero_d    = alu_zero;
          rsp0_illegal_d = sel_illegal;
        end else begin
          rsp1_valid_d   = 1'b1;
          rsp1_result_d  = alu_out;
          rsp1_carry_d   = alu_carry;
          rsp1_zero_d    = alu_zero;
          rsp1_illegal_d = sel_illegal;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      ptr_q          <= 1'b0;
      owner_q        <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_sel_q      <= '0;
      rsp0_valid_q   <= 1'b0;
      rsp0_result_q  <= '0;
      rsp0_carry_q   <= 1'b0;
      rsp0_zero_q    <= 1'b0;
      rsp0_illegal_q <= 1'b0;
      rsp1_valid_q   <= 1'b0;
      rsp1_result_q  <= '0;
      rsp1_carry_q   <= 1'b0;
      rsp1_zero_q    <= 1'b0;
      rsp1_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      owner_q        <= owner_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_sel_q      <= alu_sel_d;
      rsp0_valid_q   <= rsp0_valid_d;
      rsp0_result_q  <= rsp0_result_d;
      rsp0_carry_q   <= rsp0_carry_d;
      rsp0_zero_q    <= rsp0_zero_d;
      rsp0_illegal_q <= rsp0_illegal_d;
      rsp1_valid_q   <= rsp1_valid_d;
      rsp1_result_q  <= rsp1_result_d;
      rsp1_carry_q   <= rsp1_carry_d;
      rsp1_zero_q    <= rsp1_zero_d;
      rsp1_illegal_q <= rsp1_illegal_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_sel      = alu_sel_q;
  assign busy         = (state_q == StExec);

  assign rsp0_valid   = rsp0_valid_q;
  assign rsp0_result  = rsp0_result_q;
  assign rsp0_carry   = rsp0_carry_q;
  assign rsp0_zero    = rsp0_zero_q;
  assign rsp0_illegal = rsp0_illegal_q;

  assign rsp1_valid   = rsp1_valid_q;
  assign rsp1_result  = rsp1_result_q;
  assign rsp1_carry   = rsp1_carry_q;
  assign rsp1_zero    = rsp1_zero_q;
  assign rsp1_illegal = rsp1_illegal_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed command table plus hand-written multi-cycle sequences.
// A small behavioural 4-bit ALU answers the DUT's ALU port.
module tb_alu_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel;
  logic       rsp0_valid, rsp0_carry, rsp0_zero, rsp0_illegal;
  logic       rsp1_valid, rsp1_carry, rsp1_zero, rsp1_illegal;
  logic [3:0] rsp0_result, rsp1_result;
  logic [3:0] alu_a, alu_b, alu_sel, alu_out;
  logic       alu_carry, alu_zero, busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.DW(4), .SW(4), .MAX_SEL(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_sel     (req0_sel),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_sel     (req1_sel),
    .rsp0_valid   (rsp0_valid),
    .rsp0_result  (rsp0_result),
    .rsp0_carry   (rsp0_carry),
    .rsp0_zero    (rsp0_zero),
    .rsp0_illegal (rsp0_illegal),
    .rsp1_valid   (rsp1_valid),
    .rsp1_result  (rsp1_result),
    .rsp1_carry   (rsp1_carry),
    .rsp1_zero    (rsp1_zero),
    .rsp1_illegal (rsp1_illegal),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_out      (alu_out),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .busy         (busy)
  );

  // Behavioural ALU: 0 add, 1 sub (carry = borrow), 2 and, 3 or, 4 xor, 5 not a,
  // 6 shl, 7 rol, 8 shr; other codes give result 0, carry 0.
  always_comb begin
    logic [4:0] sum;
    sum       = 5'd0;
    alu_out   = 4'd0;
    alu_carry = 1'b0;
    case (alu_sel)
      4'd0: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = sum[3:0]; alu_carry = sum[4]; end
      4'd1: begin alu_out = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
      4'd2: alu_out = alu_a & alu_b;
      4'd3: alu_out = alu_a | alu_b;
      4'd4: alu_out = alu_a ^ alu_b;
      4'd5: alu_out = ~alu_a;
      4'd6: begin alu_out = {alu_a[2:0], 1'b0}; alu_carry = alu_a[3]; end
      4'd7: begin alu_out = {alu_a[2:0], alu_a[3]}; alu_carry = alu_a[3]; end
      4'd8: begin alu_out = {1'b0, alu_a[3:1]}; alu_carry = alu_a[0]; end
      default: begin alu_out = 4'd0; alu_carry = 1'b0; end
    endcase
    alu_zero = (alu_out == 4'd0);
  end

  typedef struct {
    logic       rid;
    logic [3:0] a, b, sel, res;
    logic       c, z, ill;
  } vec_t;

  vec_t       vecs[13];
  logic [3:0] last_res[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rid, input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] sel);
    if (!rid) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel;
    end
  endtask

  task automatic check_reset_state();
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_rsp0", {rsp0_valid, rsp0_result, rsp0_carry, rsp0_zero, rsp0_illegal}, 0);
    chk("rst_rsp1", {rsp1_valid, rsp1_result, rsp1_carry, rsp1_zero, rsp1_illegal}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_state();
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res[0] = 4'd0;
    last_res[1] = 4'd0;
  endtask

  // One command from one requester: ready in cycle 0, EXEC in cycle 1, response in cycle 2.
  task automatic run_cmd(input vec_t v);
    logic o;
    o = ~v.rid;
    @(negedge clk);
    drive(v.rid, 1'b1, v.a, v.b, v.sel);
    #1;
    chk("ready_win", v.rid ? req1_ready : req0_ready, 1);
    chk("ready_lose", v.rid ? req0_ready : req1_ready, 0);
    @(negedge clk);
    drive(v.rid, 1'b0, v.a, v.b, v.sel);
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_alu", {alu_a, alu_b, alu_sel}, {v.a, v.b, v.sel});
    chk("exec_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    @(negedge clk);
    #1;
    chk("rsp_busy", busy, 0);
    if (!v.rid) begin
      chk("rsp_valid", rsp0_valid, 1);
      chk("rsp_fields", {rsp0_result, rsp0_carry, rsp0_zero, rsp0_illegal},
          {v.res, v.c, v.z, v.ill});
    end else begin
      chk("rsp_valid", rsp1_valid, 1);
      chk("rsp_fields", {rsp1_result, rsp1_carry, rsp1_zero, rsp1_illegal},
          {v.res, v.c, v.z, v.ill});
    end
    chk("rsp_other_quiet", o ? rsp1_valid : rsp0_valid, 0);
    chk("rsp_other_held", o ? rsp1_result : rsp0_result, last_res[o]);
    last_res[v.rid] = v.res;
    @(negedge clk);
    #1;
    chk("rsp_pulse_end", v.rid ? rsp1_valid : rsp0_valid, 0);
    chk("rsp_result_held", v.rid ? rsp1_result : rsp0_result, v.res);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic       h0[$];
    logic       h1[$];
    logic       r0, r1;
    int         grants;

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0; req0_sel = 4'd0;
    req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_sel = 4'd0;

    //          rid    a      b      sel     res    c     z     ill
    vecs[0]  = '{1'b0, 4'd9, 4'd8, 4'd0,  4'd1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd2, 4'd3, 4'd1,  4'hF, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd5, 4'd5, 4'd4,  4'd0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'd5, 4'd5, 4'd10, 4'd0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 4'd9, 4'd0, 4'd7,  4'd3, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'hC, 4'hA, 4'd2,  4'd8, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'hC, 4'd3, 4'd3,  4'hF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'd8, 4'd8, 4'd0,  4'd0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'd6, 4'd0, 4'd8,  4'd3, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'd0, 4'd0, 4'd15, 4'd0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 4'hA, 4'd0, 4'd5,  4'd5, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'd9, 4'd0, 4'd6,  4'd2, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'd7, 4'd1, 4'd9,  4'd0, 1'b0, 1'b1, 1'b1};

    do_reset();
    for (int i = 0; i < 13; i++) run_cmd(vecs[i]);

    // Tie after reset: req0 wins, req1 is accepted in the cycle of rsp0.
    do_reset();
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd3, 4'd4, 4'd0);
    drive(1'b1, 1'b1, 4'd2, 4'd3, 4'd1);
    #1;
    chk("tie_ready0", req0_ready, 1);
    chk("tie_ready1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("tie_exec_alu_a", alu_a, 4'd3);
    chk("tie_exec_ready1", req1_ready, 0);
    @(negedge clk);
    #1;
    chk("tie_rsp0", {rsp0_valid, rsp0_result}, {1'b1, 4'd7});
    chk("tie_ready1_c2", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    chk("tie_exec1_alu", {busy, alu_a, alu_b, alu_sel}, {1'b1, 4'd2, 4'd3, 4'd1});
    @(negedge clk);
    #1;
    chk("tie_rsp1", {rsp1_valid, rsp1_result, rsp1_carry}, {1'b1, 4'hF, 1'b1});
    chk("tie_rsp0_quiet", rsp0_valid, 0);

    // Both continuously valid: grants alternate, each response two cycles after its ready.
    do_reset();
    grants = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      drive(1'b0, grants < 8, 4'd1, 4'd1, 4'd0);
      drive(1'b1, grants < 8, 4'd3, 4'd1, 4'd1);
      #1;
      r0 = req0_ready;
      r1 = req1_ready;
      if (r0 && r1) chk("fair_onehot", {r0, r1}, 2'b01);
      if (r0 || r1) begin
        chk("fair_order", r1, grants % 2);
        grants++;
      end
      if (cyc >= 2) begin
        chk("fair_rsp0_timing", rsp0_valid, h0[cyc - 2]);
        chk("fair_rsp1_timing", rsp1_valid, h1[cyc - 2]);
        if (rsp0_valid) chk("fair_rsp0_res", rsp0_result, 4'd2);
        if (rsp1_valid) chk("fair_rsp1_res", rsp1_result, 4'd2);
      end
      h0.push_back(r0);
      h1.push_back(r1);
    end
    chk("fair_grant_count", grants, 8);

    // Reset during EXEC discards the command and restores priority to requester 0.
    do_reset();
    run_cmd(vecs[0]);
    @(negedge clk);
    drive(1'b0, 1'b1, 4'b1001, 4'd0, 4'd7);
    #1;
    chk("mid_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 1);
    @(negedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd1, 4'd2, 4'd0);
    drive(1'b1, 1'b1, 4'd1, 4'd2, 4'd0);
    #1;
    chk("mid_tie_ready0", req0_ready, 1);
    chk("mid_tie_ready1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rsp0", {rsp0_valid, rsp0_result}, {1'b1, 4'd3});

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
